// File: rtl/gcd_controller_pkg.sv
// Shared types and constants for the GCD controller and its datapath.
// Mux encodings are named so the strobe decoder reads in datapath terms.
package gcd_controller_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CMP    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic SEL_A       = 1'b0;
  localparam logic SEL_B       = 1'b1;
  localparam logic SEL_IN_SUB  = 1'b0;
  localparam logic SEL_IN_DATA = 1'b1;

  typedef struct packed {
    logic ldA;
    logic ldB;
    logic sel1;
    logic sel2;
    logic sel_in;
  } strobes_t;

  // Exactly one comparator flag must be set; anything else means a broken datapath.
  function automatic logic flags_legal(input logic gt, input logic lt, input logic eq);
    return $onehot({gt, lt, eq});
  endfunction

endpackage

// File: rtl/gcd_controller_if.sv
// Handshake, datapath strobes, comparator flags and status between the GCD
// controller (master) and the datapath/host side (slave).
interface gcd_controller_if #(
  parameter int ITER_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              gt;
  logic              lt;
  logic              eq;
  logic              ldA;
  logic              ldB;
  logic              sel1;
  logic              sel2;
  logic              sel_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_count;

  modport master (
    input  in_valid, gt, lt, eq,
    output in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );

  modport slave (
    output in_valid, gt, lt, eq,
    input  in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
  );
endinterface

// File: rtl/gcd_controller_iter_counter.sv
// Subtraction counter: cleared when a new operand A is taken, incremented per
// subtract, saturating at MAX_ITER so it never wraps back to a small value.
module gcd_controller_iter_counter #(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ITER_W-1:0] count_o,
  output logic              at_max_o
);

  localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] count_q;
  logic [ITER_W-1:0] count_d;
  logic              at_max;

  assign at_max = (count_q == MAX_C);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max) begin
      count_d = count_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = at_max;

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath: loads A then B over
// valid/ready, iterates A-=B / B-=A until eq, and pulses done (result in A).
module gcd_controller
  import gcd_controller_pkg::*;
#(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  gcd_controller_if.master ctl_io
);

  state_e            state_q;
  state_e            state_d;
  logic              err_q;
  logic              err_d;
  strobes_t          stb;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              at_max;
  logic              flags_ok;
  logic              cmp_sub;
  logic [ITER_W-1:0] count;

  assign flags_ok = flags_legal(ctl_io.gt, ctl_io.lt, ctl_io.eq);
  // A subtract is issued only once illegal flags, eq and the limit are all ruled out.
  assign cmp_sub  = (state_q == CMP) && flags_ok && !ctl_io.eq && !at_max;

  gcd_controller_iter_counter #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .count_o  (count),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ctl_io.in_valid) begin
          err_d   = 1'b0;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (ctl_io.in_valid) begin
          state_d = CMP;
        end
      end
      CMP: begin
        if (!flags_ok) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ctl_io.eq) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (at_max) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mealy strobe decoder: loads land on the same edge the FSM advances.
  always_comb begin
    stb     = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_io.in_valid) begin
          stb.sel_in = SEL_IN_DATA;
          stb.ldA    = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      LOAD_B: begin
        if (ctl_io.in_valid) begin
          stb.sel_in = SEL_IN_DATA;
          stb.ldB    = 1'b1;
        end
      end
      CMP: begin
        if (cmp_sub) begin
          cnt_inc    = 1'b1;
          stb.sel_in = SEL_IN_SUB;
          if (ctl_io.gt) begin
            stb.sel1 = SEL_A;
            stb.sel2 = SEL_B;
            stb.ldA  = 1'b1;
          end else begin
            stb.sel1 = SEL_B;
            stb.sel2 = SEL_A;
            stb.ldB  = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign ctl_io.in_ready   = (state_q == IDLE) || (state_q == LOAD_B);
  assign ctl_io.busy       = (state_q == LOAD_B) || (state_q == CMP);
  assign ctl_io.done       = (state_q == DONE);
  assign ctl_io.err        = err_q;
  assign ctl_io.iter_count = count;
  assign ctl_io.ldA        = stb.ldA;
  assign ctl_io.ldB        = stb.ldB;
  assign ctl_io.sel1       = stb.sel1;
  assign ctl_io.sel2       = stb.sel2;
  assign ctl_io.sel_in     = stb.sel_in;

endmodule
